// File: rtl/dma_byte_packer_if.sv
// Byte-stream input and memory write port of dma_byte_packer.
//   slave  : the packer's view (consumes i_* signals, drives o_* signals)
//   master : the view of the block driving bytes/config and owning the memory port
interface dma_byte_packer_if;
    logic        i_start;
    logic [15:0] i_RCC_DMA_ADDR_HIGH;
    logic [15:0] i_RCC_DMA_ADDR_LOW;
    logic [5:0]  i_RCC_BUFFER_LENGTH;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        i_flush;
    logic        o_byte_ready;
    logic [31:0] o_mem_WRITE_addr;
    logic        o_mem_write_flag;
    logic [31:0] o_HWDATA_toMem;
    logic        i_mem_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;
    logic [5:0]  o_word_cnt;

    modport slave (
        input  i_start, i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW, i_RCC_BUFFER_LENGTH,
        input  i_byte, i_byte_valid, i_flush, i_mem_ready,
        output o_byte_ready, o_mem_WRITE_addr, o_mem_write_flag, o_HWDATA_toMem,
        output o_busy, o_done, o_overflow, o_word_cnt
    );

    modport master (
        output i_start, i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW, i_RCC_BUFFER_LENGTH,
        output i_byte, i_byte_valid, i_flush, i_mem_ready,
        input  o_byte_ready, o_mem_WRITE_addr, o_mem_write_flag, o_HWDATA_toMem,
        input  o_busy, o_done, o_overflow, o_word_cnt
    );
endinterface

// File: rtl/dma_byte_packer.sv
// Packs a serialized byte stream into 32-bit words and writes them to memory at
// consecutive word addresses starting from a latched DMA base address.
// Ports:
//   HCLK, HRESET : clock, asynchronous active-high reset
//   bus (slave)  : start/base/length config, byte stream with ready/flush,
//                  memory write port (addr/data/flag/ready), busy/done/overflow/word count
module dma_byte_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LANE_ORDER = 0
) (
    input  logic               HCLK,
    input  logic               HRESET,
    dma_byte_packer_if.slave   bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [5:0]     len_q, len_d;
    logic [5:0]     wpk_q, wpk_d;
    logic [1:0]     lane_q, lane_d;
    logic [31:0]    wbuf_q, wbuf_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    mem_q [FIFO_DEPTH];
    logic [31:0]    mem_d [FIFO_DEPTH];
    logic [5:0]     word_cnt_q, word_cnt_d;
    logic           overflow_q, overflow_d;

    logic           fifo_full;
    logic           fifo_empty;
    logic           byte_ready;
    logic           accept;
    logic           push;
    logic           pop;
    logic [1:0]     lane_acc;
    logic [31:0]    word_acc;
    logic [4:0]     lane_bit;

    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign byte_ready = (state_q == S_PACK) && !fifo_full && (wpk_q < len_q);
    assign accept     = bus.i_byte_valid && byte_ready;
    assign pop        = !fifo_empty && bus.i_mem_ready;

    // Bit position of the current lane inside the word, honouring lane order
    assign lane_bit = (LANE_ORDER != 0) ? 5'(5'd24 - {lane_q, 3'b000}) : {lane_q, 3'b000};

    // Next-state, packing and write-side bookkeeping
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wpk_d      = wpk_q;
        lane_d     = lane_q;
        wbuf_d     = wbuf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        mem_d      = mem_q;
        word_cnt_d = word_cnt_q;
        overflow_d = overflow_q;
        word_acc   = wbuf_q;
        lane_acc   = lane_q;
        push       = 1'b0;

        // Accepted byte lands first, so a same-cycle flush sees it
        if (accept) begin
            word_acc[lane_bit +: 8] = bus.i_byte;
            lane_acc                = lane_q + 2'd1;
        end

        // A completing byte wraps lane_acc to 0, which suppresses the flush
        push = (accept && (lane_q == 2'd3)) ||
               (bus.i_flush && (state_q == S_PACK) && !fifo_full && (lane_acc != 2'd0));

        if (push) begin
            mem_d[wr_ptr_q] = word_acc;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            wpk_d           = wpk_q + 6'd1;
            wbuf_d          = '0;
            lane_d          = 2'd0;
        end else begin
            wbuf_d = word_acc;
            lane_d = lane_acc;
        end

        if (pop) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            addr_d     = addr_q + 32'd4;
            word_cnt_d = word_cnt_q + 6'd1;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (bus.i_byte_valid && !byte_ready) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // FIFO is empty in IDLE, so nothing above conflicts with the latch
                if (bus.i_start) begin
                    addr_d     = {bus.i_RCC_DMA_ADDR_HIGH, bus.i_RCC_DMA_ADDR_LOW};
                    len_d      = bus.i_RCC_BUFFER_LENGTH;
                    wpk_d      = '0;
                    lane_d     = '0;
                    wbuf_d     = '0;
                    word_cnt_d = '0;
                    overflow_d = bus.i_byte_valid;
                    state_d    = (bus.i_RCC_BUFFER_LENGTH != 6'd0) ? S_PACK : S_DONE;
                end
            end
            S_PACK: begin
                if (wpk_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            wpk_q      <= '0;
            lane_q     <= '0;
            wbuf_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            mem_q      <= '{default: '0};
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wpk_q      <= wpk_d;
            lane_q     <= lane_d;
            wbuf_q     <= wbuf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
            word_cnt_q <= word_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs are direct decodes of registered state
    assign bus.o_byte_ready     = byte_ready;
    assign bus.o_mem_WRITE_addr = addr_q;
    assign bus.o_mem_write_flag = !fifo_empty;
    assign bus.o_HWDATA_toMem   = mem_q[rd_ptr_q];
    assign bus.o_busy           = (state_q != S_IDLE);
    assign bus.o_done           = (state_q == S_DONE);
    assign bus.o_overflow       = overflow_q;
    assign bus.o_word_cnt       = word_cnt_q;

endmodule
